// File: rtl/div_pkg.sv
// Shared types and width-derived constants for the iterative divider.
// Restoring division, one quotient bit per cycle.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  function automatic logic [63:0] min_pat(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit,
// try subtracting the divisor, keep the result if non-negative.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] dsr,
  input  logic             bit_in,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shf;
  logic [WIDTH:0] diff;

  assign shf  = {rem_in, bit_in};
  assign diff = shf - {1'b0, dsr};
  // rem_in < dsr keeps diff inside WIDTH+1 bits, so the MSB is the borrow
  assign q_bit   = ~diff[WIDTH];
  assign rem_out = q_bit ? diff[WIDTH-1:0] : shf[WIDTH-1:0];

endmodule

// File: rtl/div_iter_nbit.sv
// Iterative WIDTH-bit divider, signed or unsigned, valid/ready on
// both sides; zero-divisor and MIN/-1 finish in a single cycle.
module div_iter_nbit
  import div_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] odd,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [WIDTH-1:0] MIN  = WIDTH'(min_pat(WIDTH));
  localparam logic [WIDTH-1:0] ONES = '1;

  state_t state;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic             neg_q;
  logic             neg_r;

  logic             sg;
  logic             a_neg;
  logic             b_neg;
  logic             ovf_hit;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] rem_nx;
  logic             q_bit;
  logic [WIDTH-1:0] q_full;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  assign sg      = SIGNED_EN && is_signed;
  assign a_neg   = sg & A[WIDTH-1];
  assign b_neg   = sg & B[WIDTH-1];
  assign a_mag   = a_neg ? -A : A;
  assign b_mag   = b_neg ? -B : B;
  assign ovf_hit = sg && (A == MIN) && (B == ONES);

  assign in_ready = (state == IDLE);

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in (rem),
    .dsr    (dsr),
    .bit_in (dvd[cnt]),
    .rem_out(rem_nx),
    .q_bit  (q_bit)
  );

  // quo[0] is still clear when the last bit arrives
  assign q_full = quo | WIDTH'(q_bit);
  assign q_fin  = neg_q ? -q_full : q_full;
  assign r_fin  = neg_r ? -rem_nx : rem_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      dsr         <= '0;
      rem         <= '0;
      quo         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      result      <= '0;
      odd         <= '0;
      out_valid   <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            if (B == '0) begin
              result      <= ONES;
              odd         <= A;
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else if (ovf_hit) begin
              result      <= MIN;
              odd         <= '0;
              div_by_zero <= 1'b0;
              overflow    <= 1'b1;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              dvd   <= a_mag;
              dsr   <= b_mag;
              rem   <= '0;
              quo   <= '0;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              cnt   <= CW'(WIDTH - 1);
              state <= RUN;
            end
          end
        end
        RUN: begin
          rem      <= rem_nx;
          quo[cnt] <= q_bit;
          if (cnt == '0) begin
            result      <= q_fin;
            odd         <= r_fin;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter_nbit.sv
// Randomised bench for div_iter_nbit at WIDTH 16/8/32 and unsigned-only 8,
// checked against an arithmetic reference model.
module tb_div_iter_nbit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] a_d = '0;
  logic [63:0] b_d = '0;
  logic        sg_d = 1'b0;
  logic        iv = 1'b0;
  logic        ordy = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [3:0]  in_v;

  logic [15:0] r0, o0;
  logic [7:0]  r1, o1;
  logic [31:0] r2, o2;
  logic [7:0]  r3, o3;
  logic [3:0]  irdy, ov, dz, of;

  logic [63:0] cur_res, cur_odd;
  logic        cur_ov, cur_irdy, cur_dz, cur_of;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        chk_en = 1'b0;
  logic [63:0] exp_q, exp_r;
  bit          exp_dz, exp_of;
  int          exp_lat;
  logic [63:0] last_q, last_r;
  logic        last_dz, last_of;
  int          last_lat;

  always #5 clk = ~clk;

  assign in_v = iv ? (4'b1 << sel) : 4'b0;

  div_iter_nbit #(.WIDTH(16), .SIGNED_EN(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_v[0]), .in_ready(irdy[0]),
    .A(a_d[15:0]), .B(b_d[15:0]), .is_signed(sg_d), .out_valid(ov[0]),
    .out_ready(ordy), .result(r0), .odd(o0),
    .div_by_zero(dz[0]), .overflow(of[0]));

  div_iter_nbit #(.WIDTH(8), .SIGNED_EN(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_v[1]), .in_ready(irdy[1]),
    .A(a_d[7:0]), .B(b_d[7:0]), .is_signed(sg_d), .out_valid(ov[1]),
    .out_ready(ordy), .result(r1), .odd(o1),
    .div_by_zero(dz[1]), .overflow(of[1]));

  div_iter_nbit #(.WIDTH(32), .SIGNED_EN(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_v[2]), .in_ready(irdy[2]),
    .A(a_d[31:0]), .B(b_d[31:0]), .is_signed(sg_d), .out_valid(ov[2]),
    .out_ready(ordy), .result(r2), .odd(o2),
    .div_by_zero(dz[2]), .overflow(of[2]));

  div_iter_nbit #(.WIDTH(8), .SIGNED_EN(1'b0)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_v[3]), .in_ready(irdy[3]),
    .A(a_d[7:0]), .B(b_d[7:0]), .is_signed(sg_d), .out_valid(ov[3]),
    .out_ready(ordy), .result(r3), .odd(o3),
    .div_by_zero(dz[3]), .overflow(of[3]));

  always_comb begin
    cur_res = '0;
    cur_odd = '0;
    case (sel)
      2'd0: begin cur_res = 64'(r0); cur_odd = 64'(o0); end
      2'd1: begin cur_res = 64'(r1); cur_odd = 64'(o1); end
      2'd2: begin cur_res = 64'(r2); cur_odd = 64'(o2); end
      default: begin cur_res = 64'(r3); cur_odd = 64'(o3); end
    endcase
    cur_ov   = ov[sel];
    cur_irdy = irdy[sel];
    cur_dz   = dz[sel];
    cur_of   = of[sel];
  end

  function automatic int wof(input logic [1:0] s);
    case (s)
      2'd0:    return 16;
      2'd1:    return 8;
      2'd2:    return 32;
      default: return 8;
    endcase
  endfunction

  function automatic bit sen(input logic [1:0] s);
    return s != 2'd3;
  endfunction

  // Reference: plain integer division with C-style truncation
  task automatic model(input int w, input logic [63:0] a, input logic [63:0] b,
                       input bit sg, output logic [63:0] q,
                       output logic [63:0] r, output bit dzo, output bit ovo);
    longint m, am, bm, sa, sb;
    m  = (longint'(1) << w) - 1;
    am = longint'(a) & m;
    bm = longint'(b) & m;
    dzo = 1'b0;
    ovo = 1'b0;
    if (bm == 0) begin
      q = 64'(m);
      r = 64'(am);
      dzo = 1'b1;
    end else if (sg && am == (longint'(1) << (w - 1)) && bm == m) begin
      q = 64'(am);
      r = '0;
      ovo = 1'b1;
    end else begin
      sa = (sg && am[w-1]) ? am - (m + 1) : am;
      sb = (sg && bm[w-1]) ? bm - (m + 1) : bm;
      q = 64'((sa / sb) & m);
      r = 64'((sa % sb) & m);
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && cur_ov) begin
      chk("result", cur_res, exp_q);
      chk("odd", cur_odd, exp_r);
      chk("div_by_zero", 64'(cur_dz), 64'(exp_dz));
      chk("overflow", 64'(cur_of), 64'(exp_of));
      chk("in_ready_busy", 64'(cur_irdy), 64'd0);
    end
  end

  task automatic do_op(input logic [1:0] s, input logic [63:0] a,
                       input logic [63:0] b, input bit sg, input int stall);
    int n;
    sel  = s;
    a_d  = a;
    b_d  = b;
    sg_d = sg;
    model(wof(s), a, b, sg && sen(s), exp_q, exp_r, exp_dz, exp_of);
    exp_lat = (exp_dz || exp_of) ? 1 : wof(s) + 1;
    n = 0;
    while (!cur_irdy && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_before", 64'(cur_irdy), 64'd1);
    iv = 1'b1;
    @(posedge clk); #1;
    // scramble inputs and keep requesting; a busy unit must ignore both
    a_d  = {$urandom, $urandom};
    b_d  = {$urandom, $urandom};
    sg_d = ~sg;
    chk_en = 1'b1;
    n = 1;
    while (!cur_ov && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", 64'(n), 64'(exp_lat));
    last_q = cur_res;
    last_r = cur_odd;
    last_dz = cur_dz;
    last_of = cur_of;
    last_lat = n;
    repeat (stall) begin
      @(posedge clk); #1;
    end
    iv = 1'b0;
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    chk_en = 1'b0;
    chk("valid_drop", 64'(cur_ov), 64'd0);
    chk("ready_after", 64'(cur_irdy), 64'd1);
  endtask

  task automatic pin(input string nm, input logic [63:0] q, input logic [63:0] r,
                     input bit d, input bit o);
    chk({nm, "_q"}, last_q, q);
    chk({nm, "_r"}, last_r, r);
    chk({nm, "_flags"}, {62'd0, last_dz, last_of}, {62'd0, d, o});
  endtask

  initial begin
    logic [63:0] mq, mr, ra, rb;
    bit md, mo;
    int seen;

    model(16, 64'd100, 64'd7, 1'b0, mq, mr, md, mo);
    chk("model_u", {mq[31:0], mr[31:0]}, {32'd14, 32'd2});
    model(16, 64'hFF9C, 64'd7, 1'b1, mq, mr, md, mo);
    chk("model_s", {mq[31:0], mr[31:0]}, {32'hFFF2, 32'hFFFE});
    model(8, 64'h80, 64'hFF, 1'b1, mq, mr, md, mo);
    chk("model_ovf", {mq[31:0], 31'd0, mo}, {32'h80, 32'd1});

    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk("rst_res", cur_res | cur_odd, 64'd0);
      chk("rst_flags", {60'd0, cur_ov, cur_dz, cur_of, cur_irdy}, 64'd1);
    end
    rst_n = 1'b1;

    do_op(2'd0, 64'd100, 64'd7, 1'b0, 0);
    pin("u100_7", 64'd14, 64'd2, 1'b0, 1'b0);
    chk("lat17", 64'(last_lat), 64'd17);
    do_op(2'd0, 64'hFF9C, 64'd7, 1'b1, 1);
    pin("sm100_7", 64'hFFF2, 64'hFFFE, 1'b0, 1'b0);
    do_op(2'd0, 64'd100, 64'hFFF9, 1'b1, 0);
    pin("s100_m7", 64'hFFF2, 64'd2, 1'b0, 1'b0);
    do_op(2'd0, 64'h1234, 64'd0, 1'b0, 0);
    pin("dz", 64'hFFFF, 64'h1234, 1'b1, 1'b0);
    chk("lat_dz", 64'(last_lat), 64'd1);
    do_op(2'd0, 64'h8000, 64'hFFFF, 1'b1, 5);
    pin("ovf", 64'h8000, 64'd0, 1'b0, 1'b1);
    do_op(2'd3, 64'h9C, 64'd7, 1'b1, 0);
    pin("nosign", 64'd22, 64'd2, 1'b0, 1'b0);
    do_op(2'd0, 64'hFFF9, 64'd7, 1'b1, 0);
    pin("exact", 64'hFFFF, 64'd0, 1'b0, 1'b0);

    sel = 2'd0;
    a_d = 64'd1000;
    b_d = 64'd3;
    sg_d = 1'b0;
    iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_res", cur_res | cur_odd, 64'd0);
    chk("midrst_flags", {60'd0, cur_ov, cur_dz, cur_of, cur_irdy}, 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (|ov) seen++;
    end
    chk("midrst_no_valid", 64'(seen), 64'd0);

    for (int s = 0; s < 4; s++) begin
      repeat (40) begin
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        case ($urandom_range(0, 7))
          0: rb = '0;
          1: rb = '1;
          2: rb = 64'd1;
          3: ra = 64'd1 << (wof(2'(s)) - 1);
          4: begin ra = 64'd1 << (wof(2'(s)) - 1); rb = '1; end
          5: ra = 64'(ra[3:0]);
          default: ;
        endcase
        do_op(2'(s), ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_iter_nbit.md
DIV_ITER_NBIT -- requirements
Module: div_iter_nbit

Interface
REQ-001 Parameter WIDTH SHALL default to 16 and set operand/result width; legal range 4..64.
REQ-002 Parameter SIGNED_EN SHALL default to 1; when 0, the is_signed input SHALL be ignored and all divisions are unsigned.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  request carries a valid operand pair.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 A  input  WIDTH  dividend.
REQ-008 B  input  WIDTH  divisor.
REQ-009 is_signed  input  1  treat A/B as two's complement, sampled with the request.
REQ-010 out_valid  output  1  result, odd and flags are valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 result  output  WIDTH  quotient.
REQ-013 odd  output  WIDTH  remainder.
REQ-014 div_by_zero  output  1  B was zero.
REQ-015 overflow  output  1  signed MIN / -1 occurred.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 IDLE: on in_valid && in_ready, A, B and is_signed SHALL be captured; next state RUN, or DONE when B==0 or the overflow case applies.
REQ-018 RUN: one restoring step per cycle, quotient bits produced MSB first, bit counter from WIDTH-1 down to 0; after the step at counter 0, next state DONE.
REQ-019 Latency: for a normal request, out_valid SHALL rise exactly WIDTH+1 rising edges after the accepting edge; for div-by-zero/overflow, exactly 1 edge after it.
REQ-020 Signed mode: operands converted to magnitudes; quotient truncates toward zero; remainder sign SHALL equal dividend sign; odd SHALL be 0 whenever the remainder is zero.
REQ-021 Invariant for non-exception cases: A == result*B + odd (in the selected signedness), |odd| < |B|.
REQ-022 B==0: result SHALL be all ones, odd SHALL equal A, div_by_zero=1, overflow=0.
REQ-023 Signed A==MIN, B==-1: result SHALL equal MIN, odd=0, overflow=1, div_by_zero=0.
REQ-024 DONE: outputs SHALL hold stable while out_valid && !out_ready; on out_ready the next state SHALL be IDLE (no acceptance in the same cycle).
REQ-025 in_valid while not in_ready SHALL be ignored; A/B changes during RUN SHALL NOT affect the result.
REQ-026 Flags SHALL be 0 for every normal completion.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE and result=0, odd=0, out_valid=0, div_by_zero=0, overflow=0, counter=0; in_ready SHALL be 1 while in reset.
REQ-028 Reset asserted during RUN or DONE SHALL discard the operation; no out_valid SHALL follow.
REQ-029 First acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-030 Shared package div_pkg SHALL hold the FSM state type (IDLE/RUN/DONE) and the width-dependent constants (counter width, signed MIN pattern).
REQ-031 One sub-module div_step (combinational: partial remainder, divisor, next dividend bit -> new remainder, quotient bit) SHALL implement a single restoring iteration.
REQ-032 Total RTL SHALL be single-clock, no latches, no combinational path from in_valid to out_valid.

Verification
REQ-033 Unsigned WIDTH=16: A=100, B=7 -> result=14, odd=2, out_valid 17 edges after acceptance.
REQ-034 Signed: A=-100, B=7 -> result=-14, odd=-2; A=100, B=-7 -> result=-14, odd=2; flags 0.
REQ-035 B=0, A=0x1234 -> result=0xFFFF, odd=0x1234, div_by_zero=1, out_valid after 1 edge.
REQ-036 Signed A=0x8000, B=0xFFFF -> result=0x8000, odd=0, overflow=1.
REQ-037 Backpressure: out_ready held low 5 cycles -> outputs stable, in_ready=0; rst_n pulsed mid-RUN -> outputs zero, no out_valid.
REQ-038 Random sweep at WIDTH=8 and 32, both modes, versus reference model per REQ-021.
